// File: rtl/main_mem_port_if.sv
// Request/response bundle between the core's memory control logic and main_mem_port.
// The master side issues reads and writes; the slave side returns tagged read data.
interface main_mem_if #(
    parameter int MAIN_ADDR_WIDTH = 1,
    parameter int WORD_WIDTH      = 32
);
    logic                       write_out;
    logic [MAIN_ADDR_WIDTH-1:0] write_address;
    logic [WORD_WIDTH-1:0]      write_value;
    logic [MAIN_ADDR_WIDTH-1:0] read_address;
    logic                       reload;
    logic [1:0]                 choice;
    logic                       dstack_memload;
    logic                       conveyor_memload;
    logic                       stream_out;
    logic [WORD_WIDTH-1:0]      read_value;
    logic                       dstack_load_valid;
    logic                       conveyor_load_valid;
    logic                       dc_reload_valid;
    logic [1:0]                 dc_reload_index;
    logic                       stream_out_valid;
    logic [3:0]                 dc_pending;
    logic                       protocol_error;

    modport master (
        output write_out, write_address, write_value, read_address,
        output reload, choice, dstack_memload, conveyor_memload, stream_out,
        input  read_value, dstack_load_valid, conveyor_load_valid,
        input  dc_reload_valid, dc_reload_index, stream_out_valid,
        input  dc_pending, protocol_error
    );

    modport slave (
        input  write_out, write_address, write_value, read_address,
        input  reload, choice, dstack_memload, conveyor_memload, stream_out,
        output read_value, dstack_load_valid, conveyor_load_valid,
        output dc_reload_valid, dc_reload_index, stream_out_valid,
        output dc_pending, protocol_error
    );
endinterface

// File: rtl/main_mem_port.sv
// Main-memory responder: owns the array, returns read data through a fixed-latency tagged
// pipeline with per-DC reload cancel. MAIN_MEM_PORT_RW_FORWARD_EN forwards same-edge write data to reads.
module main_mem_port #(
    parameter int MAIN_ADDR_WIDTH = 1,
    parameter int WORD_WIDTH      = 32,
    parameter int READ_LATENCY    = 2
) (
    input  logic     clk,
    input  logic     reset,
    main_mem_if.slave mp
);
    localparam int DEPTH = 1 << MAIN_ADDR_WIDTH;

    typedef enum logic [1:0] {
        KIND_DSTACK   = 2'd0,
        KIND_CONVEYOR = 2'd1,
        KIND_DC       = 2'd2,
        KIND_STREAM   = 2'd3
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [1:0] index;
    } tag_t;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [READ_LATENCY:1] vld_pipe, nxt_vld;
    tag_t                  tag_pipe  [READ_LATENCY:1];
    tag_t                  nxt_tag   [READ_LATENCY:1];
    logic [WORD_WIDTH-1:0] data_pipe [READ_LATENCY:1];
    logic [WORD_WIDTH-1:0] nxt_data  [READ_LATENCY:1];

    logic [3:0]            dc_pending_q, pending_nxt;
    logic                  perr_q;
    logic                  rd_req, multi_req;
    tag_t                  req_tag;
    logic [WORD_WIDTH-1:0] rd_data;

    assign rd_req    = mp.reload | mp.dstack_memload | mp.conveyor_memload | mp.stream_out;
    assign multi_req = $countones({mp.reload, mp.dstack_memload,
                                   mp.conveyor_memload, mp.stream_out}) > 1;

    always_comb begin
        req_tag = '{kind: KIND_STREAM, index: 2'd0};
        if (mp.reload)                req_tag = '{kind: KIND_DC, index: mp.choice};
        else if (mp.dstack_memload)   req_tag.kind = KIND_DSTACK;
        else if (mp.conveyor_memload) req_tag.kind = KIND_CONVEYOR;
    end

`ifdef MAIN_MEM_PORT_RW_FORWARD_EN
    assign rd_data = (mp.write_out && mp.write_address == mp.read_address) ?
                     mp.write_value : mem[mp.read_address];
`else
    assign rd_data = mem[mp.read_address];
`endif

    // Stage advance; an incoming reload kills older responses for the same DC as they shift.
    always_comb begin
        nxt_vld     = '0;
        nxt_vld[1]  = rd_req;
        nxt_tag[1]  = req_tag;
        nxt_data[1] = rd_data;
        for (int s = 2; s <= READ_LATENCY; s++) begin
            nxt_vld[s]  = vld_pipe[s-1] &&
                          !(mp.reload && tag_pipe[s-1].kind == KIND_DC &&
                            tag_pipe[s-1].index == mp.choice);
            nxt_tag[s]  = tag_pipe[s-1];
            nxt_data[s] = data_pipe[s-1];
        end
        pending_nxt = '0;
        for (int s = 1; s <= READ_LATENCY; s++)
            if (nxt_vld[s] && nxt_tag[s].kind == KIND_DC)
                pending_nxt[nxt_tag[s].index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe     <= '0;
            dc_pending_q <= '0;
            perr_q       <= 1'b0;
        end else begin
            vld_pipe     <= nxt_vld;
            dc_pending_q <= pending_nxt;
            for (int s = 1; s <= READ_LATENCY; s++) begin
                tag_pipe[s]  <= nxt_tag[s];
                data_pipe[s] <= nxt_data[s];
            end
            if (multi_req) perr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mp.write_out) mem[mp.write_address] <= mp.write_value;
    end

    logic out_v;
    tag_t out_tag;
    assign out_v   = vld_pipe[READ_LATENCY];
    assign out_tag = tag_pipe[READ_LATENCY];

    assign mp.read_value          = out_v ? data_pipe[READ_LATENCY] : '0;
    assign mp.dstack_load_valid   = out_v && out_tag.kind == KIND_DSTACK;
    assign mp.conveyor_load_valid = out_v && out_tag.kind == KIND_CONVEYOR;
    assign mp.dc_reload_valid     = out_v && out_tag.kind == KIND_DC;
    assign mp.dc_reload_index     = (out_v && out_tag.kind == KIND_DC) ? out_tag.index : 2'd0;
    assign mp.stream_out_valid    = out_v && out_tag.kind == KIND_STREAM;
    assign mp.dc_pending          = dc_pending_q;
    assign mp.protocol_error      = perr_q;
endmodule

// File: tb/tb_main_mem_port.sv
// Self-checking bench for main_mem_port: directed scenarios plus random traffic against a
// request-list reference model (each read remembered with its issue cycle, kind and data).
module tb_main_mem_port;
    localparam int AW = 4;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    main_mem_if #(.MAIN_ADDR_WIDTH(AW), .WORD_WIDTH(32)) mif ();

    main_mem_port #(.MAIN_ADDR_WIDTH(AW), .WORD_WIDTH(32), .READ_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .mp    (mif.slave)
    );

    // kinds: 0 dstack, 1 conveyor, 2 DC reload, 3 stream
    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] data;
        bit          alive;
    } rec_t;

    rec_t        q[$];
    logic [31:0] smem [1<<AW];
    bit          perr_m = 1'b0;
    bit          known  = 1'b0;
    int          checks = 0, failures = 0, cyc = 0;
    logic [10:0] ev;

`ifdef MAIN_MEM_PORT_RW_FORWARD_EN
    localparam logic [31:0] RW_EXP = 32'h5;
`else
    localparam logic [31:0] RW_EXP = 32'h9;
`endif

    task automatic drive(input bit w, input int wa, input logic [31:0] wv, input int ra,
                         input bit rl, input int ch, input bit ds, input bit cv, input bit so);
        mif.write_out        = w;
        mif.write_address    = wa[AW-1:0];
        mif.write_value      = wv;
        mif.read_address     = ra[AW-1:0];
        mif.reload           = rl;
        mif.choice           = ch[1:0];
        mif.dstack_memload   = ds;
        mif.conveyor_memload = cv;
        mif.stream_out       = so;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    endtask

    // Model the edge that ends cycle cyc.
    task automatic model_sample();
        int   nk, ra, wa;
        rec_t r;
        if (reset) begin
            foreach (q[k]) q[k].alive = 1'b0;
            perr_m = 1'b0;
            known  = 1'b1;
            return;
        end
        ra = int'(mif.read_address);
        wa = int'(mif.write_address);
        nk = int'(mif.reload) + int'(mif.dstack_memload) + int'(mif.conveyor_memload) + int'(mif.stream_out);
        if (nk > 1) perr_m = 1'b1;
        if (nk > 0) begin
            r.kind  = mif.reload ? 2 : mif.dstack_memload ? 0 : mif.conveyor_memload ? 1 : 3;
            r.idx   = mif.reload ? int'(mif.choice) : 0;
            r.cyc   = cyc;
            r.alive = 1'b1;
            r.data  = smem[ra];
`ifdef MAIN_MEM_PORT_RW_FORWARD_EN
            if (mif.write_out && wa == ra) r.data = mif.write_value;
`endif
            if (mif.reload)
                foreach (q[k])
                    if (q[k].alive && q[k].kind == 2 && q[k].idx == r.idx && q[k].cyc + L > cyc)
                        q[k].alive = 1'b0;
            q.push_back(r);
        end
        if (mif.write_out) smem[wa] = mif.write_value;
        while (q.size() > 0 && q[0].cyc + L < cyc) void'(q.pop_front());
    endtask

    task automatic tick();
        model_sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [10:0] exp_vec(int m);
        logic d = 0, c = 0, r = 0, s = 0;
        logic [1:0] ix = 0;
        logic [3:0] p = 0;
        foreach (q[k]) if (q[k].alive) begin
            if (q[k].cyc + L == m) begin
                case (q[k].kind)
                    0: d = 1;
                    1: c = 1;
                    2: begin r = 1; ix = q[k].idx[1:0]; end
                    default: s = 1;
                endcase
            end
            if (q[k].kind == 2 && q[k].cyc < m && m <= q[k].cyc + L) p[q[k].idx] = 1'b1;
        end
        return {d, c, r, ix, s, p, perr_m};
    endfunction

    function automatic bit exp_any(int m);
        foreach (q[k]) if (q[k].alive && q[k].cyc + L == m) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_data(int m);
        foreach (q[k]) if (q[k].alive && q[k].cyc + L == m) return q[k].data;
        return 32'h0;
    endfunction

    function automatic logic [10:0] obs_vec();
        return {mif.dstack_load_valid, mif.conveyor_load_valid, mif.dc_reload_valid,
                mif.dc_reload_index, mif.stream_out_valid, mif.dc_pending, mif.protocol_error};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            reset = (i < 3);
            idle();
            @(negedge clk);
            if (known) begin
                checks++;
                if (obs_vec() !== 11'h0 || mif.read_value !== 32'h0) begin
                    failures++;
                    $display("FAIL reset cyc=%0d got flags=%h rv=%h exp 0", cyc, obs_vec(), mif.read_value);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        for (int a = 0; a < (1<<AW); a++) begin
            drive(1, a, $urandom, 0, 0, 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
                1: drive(0, 0, 32'h0, 1, 0, 0, 1, 0, 0);
                default: idle();
            endcase
            @(negedge clk);
            ev = exp_vec(cyc);
            checks++;
            if (obs_vec() !== ev) begin
                failures++;
                $display("FAIL write_read cyc=%0d flags got=%h exp=%h", cyc, obs_vec(), ev);
            end
            checks++;
            if (mif.dstack_load_valid !== (i == 3) ||
                (i == 3 && mif.read_value !== 32'hDEADBEEF)) begin
                failures++;
                $display("FAIL write_read_dstack i=%0d got v=%b rv=%h exp v=%b rv=deadbeef",
                         i, mif.dstack_load_valid, mif.read_value, i == 3);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(0, 0, 32'h0, 0, 1, 2, 0, 0, 0);
                1: drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 0);
                2: drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 1);
                default: idle();
            endcase
            @(negedge clk);
            ev = exp_vec(cyc);
            checks++;
            if (obs_vec() !== ev) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d flags got=%h exp=%h", cyc, obs_vec(), ev);
            end
            if (exp_any(cyc)) begin
                checks++;
                if (mif.read_value !== exp_data(cyc)) begin
                    failures++;
                    $display("FAIL back_to_back_data cyc=%0d got=%h exp=%h", cyc, mif.read_value, exp_data(cyc));
                end
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (mif.dc_pending !== 4'b0100) begin
                    failures++;
                    $display("FAIL back_to_back_pending i=%0d got=%b exp=0100", i, mif.dc_pending);
                end
            end
            tick();
        end
    endtask

    task automatic test_reload_cancel();
        int n_valid = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 2) drive(0, 0, 32'h0, 5, 1, 1, 0, 0, 0);
            else idle();
            @(negedge clk);
            ev = exp_vec(cyc);
            checks++;
            if (obs_vec() !== ev) begin
                failures++;
                $display("FAIL reload_cancel cyc=%0d flags got=%h exp=%h", cyc, obs_vec(), ev);
            end
            if (mif.dc_reload_valid === 1'b1) n_valid++;
            checks++;
            if (mif.dc_pending[1] !== (i >= 1 && i <= 3)) begin
                failures++;
                $display("FAIL reload_cancel_pending i=%0d got=%b exp=%b", i, mif.dc_pending[1], i >= 1 && i <= 3);
            end
            tick();
        end
        checks++;
        if (n_valid != 1) begin
            failures++;
            $display("FAIL reload_cancel_count got=%0d exp=1", n_valid);
        end
    endtask

    task automatic test_rw_same_edge();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1, 0, 32'h9, 0, 0, 0, 0, 0, 0);
                1: drive(1, 0, 32'h5, 0, 0, 0, 1, 0, 0);
                default: idle();
            endcase
            @(negedge clk);
            ev = exp_vec(cyc);
            checks++;
            if (obs_vec() !== ev) begin
                failures++;
                $display("FAIL rw_same_edge cyc=%0d flags got=%h exp=%h", cyc, obs_vec(), ev);
            end
            if (i == 3) begin
                checks++;
                if (mif.read_value !== RW_EXP || mif.dstack_load_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rw_same_edge_data got=%h v=%b exp=%h v=1", mif.read_value, mif.dstack_load_valid, RW_EXP);
                end
            end
            tick();
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(0, 0, 32'h0, 2, 1, 0, 1, 0, 0);
            else idle();
            @(negedge clk);
            ev = exp_vec(cyc);
            checks++;
            if (obs_vec() !== ev) begin
                failures++;
                $display("FAIL priority cyc=%0d flags got=%h exp=%h", cyc, obs_vec(), ev);
            end
            checks++;
            if (mif.protocol_error !== (i >= 1) || mif.dstack_load_valid !== 1'b0 ||
                mif.dc_reload_valid !== (i == 2)) begin
                failures++;
                $display("FAIL priority_explicit i=%0d got perr=%b ds=%b dc=%b", i,
                         mif.protocol_error, mif.dstack_load_valid, mif.dc_reload_valid);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int sel = $urandom_range(0, 15);
            drive($urandom_range(0, 1), $urandom_range(0, (1<<AW)-1), $urandom,
                  $urandom_range(0, (1<<AW)-1),
                  sel == 0 || sel == 4 || sel == 12, $urandom_range(0, 3),
                  sel == 1 || sel == 5 || sel == 12, sel == 2 || sel == 6, sel == 3 || sel == 7);
            @(negedge clk);
            ev = exp_vec(cyc);
            checks++;
            if (obs_vec() !== ev) begin
                failures++;
                $display("FAIL random cyc=%0d flags got=%h exp=%h", cyc, obs_vec(), ev);
            end
            if (exp_any(cyc)) begin
                checks++;
                if (mif.read_value !== exp_data(cyc)) begin
                    failures++;
                    $display("FAIL random_data cyc=%0d got=%h exp=%h", cyc, mif.read_value, exp_data(cyc));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 6; i++) begin
            reset = (i == 1);
            case (i)
                0: drive(0, 0, 32'h0, 3, 1, 3, 0, 0, 0);
                1: drive(0, 0, 32'h0, 4, 0, 0, 0, 1, 0);
                default: idle();
            endcase
            @(negedge clk);
            ev = exp_vec(cyc);
            checks++;
            if (obs_vec() !== ev) begin
                failures++;
                $display("FAIL reset_inflight cyc=%0d flags got=%h exp=%h", cyc, obs_vec(), ev);
            end
            if (i >= 2) begin
                checks++;
                if (obs_vec() !== 11'h0) begin
                    failures++;
                    $display("FAIL reset_inflight_clear i=%0d got=%h exp=0", i, obs_vec());
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reload_cancel();
        test_rw_same_edge();
        test_priority();
        test_random();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
